// File: rtl/tdc_sequencer.sv
// Burst sequencer for a TDC core: arms, waits for a measurement or timeout, emits results.
// Optional min/max burst statistics are built only when TDC_SEQ_STATS_EN is defined.
module tdc_sequencer #(
  parameter int TIMEOUT_W = 28,
  parameter int RST_HOLD  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           burst_len,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 tdc_arm,
  output logic                 tdc_rst_n,
  input  logic [39:0]          tdc_meas,
  input  logic                 tdc_valid,
  input  logic [1:0]           tdc_state,
  output logic [39:0]          out_data,
  output logic                 out_timeout,
  output logic [7:0]           out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [39:0]          min_meas,
  output logic [39:0]          max_meas
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, EMIT, RECOVER, FIN} state_t;

  state_t               state, state_nxt;
  logic [7:0]           len_q;
  logic [7:0]           idx;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [3:0]           rec_cnt;
  logic                 aborting;
  logic [39:0]          data_q;
  logic                 timeout_q;

  logic start_ok, capture, expire, xfer, last_idx, rec_last, abort_hit;

  assign abort_hit = abort && (state != IDLE);
  assign start_ok  = (state == IDLE) && start && (burst_len != 8'd0);
  // A valid strobe takes priority over an expiring counter in the same cycle.
  assign capture   = (state == WAIT) && tdc_valid && !abort;
  assign expire    = (state == WAIT) && !tdc_valid && !abort &&
                     (timeout_cycles != '0) && (wait_cnt == timeout_cycles);
  assign xfer      = (state == EMIT) && out_ready && !abort;
  assign last_idx  = (idx == len_q - 8'd1);
  assign rec_last  = (state == RECOVER) && (rec_cnt == 4'(RST_HOLD - 1));

  assign tdc_arm     = (state == ARM) && (tdc_state == 2'd0) && !abort;
  assign tdc_rst_n   = !rst && (state != RECOVER);
  assign out_valid   = (state == EMIT);
  assign out_data    = data_q;
  assign out_timeout = timeout_q;
  assign out_idx     = idx;
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = ARM;
      ARM:     if (tdc_state == 2'd0) state_nxt = WAIT;
      WAIT: begin
        if (tdc_valid)   state_nxt = EMIT;
        else if (expire) state_nxt = RECOVER;
      end
      EMIT:    if (out_ready) state_nxt = last_idx ? FIN : ARM;
      RECOVER: if (rec_last) state_nxt = aborting ? IDLE : EMIT;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = RECOVER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= 8'd0;
      idx       <= 8'd0;
      wait_cnt  <= '0;
      rec_cnt   <= 4'd0;
      aborting  <= 1'b0;
      data_q    <= 40'd0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + TIMEOUT_W'(1) : '0;
      // An abort arriving during RECOVER restarts the reset hold.
      rec_cnt  <= ((state == RECOVER) && !abort) ? rec_cnt + 4'd1 : 4'd0;
      if (start_ok) begin
        len_q    <= burst_len;
        idx      <= 8'd0;
        aborting <= 1'b0;
      end
      if (xfer && !last_idx) idx <= idx + 8'd1;
      if (abort_hit) aborting <= 1'b1;
      if (capture) begin
        data_q    <= tdc_meas;
        timeout_q <= 1'b0;
      end else if (expire) begin
        data_q    <= 40'd0;
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef TDC_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      min_meas <= 40'hFF_FFFF_FFFF;
      max_meas <= 40'd0;
    end else if (capture) begin
      if (tdc_meas < min_meas) min_meas <= tdc_meas;
      if (tdc_meas > max_meas) max_meas <= tdc_meas;
    end
  end
`else
  assign min_meas = 40'd0;
  assign max_meas = 40'd0;
`endif

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed self-checking bench for tdc_sequencer (default parameters).
module tb_tdc_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, tdc_valid, out_ready;
  logic [7:0]  burst_len;
  logic [27:0] timeout_cycles;
  logic [39:0] tdc_meas;
  logic [1:0]  tdc_state;
  logic        tdc_arm, tdc_rst_n, out_timeout, out_valid, busy, done;
  logic [39:0] out_data, min_meas, max_meas;
  logic [7:0]  out_idx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, arm_cnt = 0, rise_cnt = 0, rstlow_cnt = 0;
  int d0, a0, r0, v0;
  logic prev_valid = 1'b0;

  tdc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .burst_len(burst_len), .timeout_cycles(timeout_cycles),
    .tdc_arm(tdc_arm), .tdc_rst_n(tdc_rst_n), .tdc_meas(tdc_meas),
    .tdc_valid(tdc_valid), .tdc_state(tdc_state), .out_data(out_data),
    .out_timeout(out_timeout), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done),
    .min_meas(min_meas), .max_meas(max_meas)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (tdc_arm) arm_cnt++;
      if (out_valid && !prev_valid) rise_cnt++;
      if (!tdc_rst_n) rstlow_cnt++;
    end
    prev_valid = out_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Entered in the ARM cycle; leaves the bench in the EMIT cycle of that result.
  task automatic applyStimulus(input logic [39:0] meas, input logic [7:0] idx_exp);
    tick(1);
    checkOutput("wait_arm_low", tdc_arm, 0);
    tdc_meas  = meas;
    tdc_valid = 1'b1;
    tick(1);
    tdc_valid = 1'b0;
    checkOutput("emit_valid", out_valid, 1);
    checkOutput("emit_data", out_data, meas);
    checkOutput("emit_timeout", out_timeout, 0);
    checkOutput("emit_idx", out_idx, idx_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tdc_valid = 1'b0; out_ready = 1'b0;
    burst_len = 8'd0; timeout_cycles = 28'd0; tdc_meas = 40'd0; tdc_state = 2'd0;
    tick(2);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tdc_rst_n", tdc_rst_n, 0);
    checkOutput("rst_arm", tdc_arm, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    checkOutput("rst_done", done, 0);
`ifdef TDC_SEQ_STATS_EN
    checkOutput("rst_min", min_meas, 40'hFF_FFFF_FFFF);
`else
    checkOutput("rst_min", min_meas, 0);
`endif
    checkOutput("rst_max", max_meas, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_release_tdc_rst_n", tdc_rst_n, 1);

    $display("[TB] three-measurement burst");
    burst_len = 8'd3; out_ready = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("b3_arm_latency", tdc_arm, 1);
    checkOutput("b3_busy", busy, 1);
    applyStimulus(40'h100, 8'd0);
    tick(1);
    checkOutput("b3_valid_drop", out_valid, 0);
    checkOutput("b3_arm1", tdc_arm, 1);
    applyStimulus(40'h0C0, 8'd1);
    tick(1);
    checkOutput("b3_arm2", tdc_arm, 1);
    applyStimulus(40'h140, 8'd2);
    tick(1);
    checkOutput("b3_done", done, 1);
    checkOutput("b3_fin_valid", out_valid, 0);
    tick(1);
    checkOutput("b3_done_pulse", done, 0);
    checkOutput("b3_idle", busy, 0);
    checkOutput("b3_done_count", done_cnt, 1);
`ifdef TDC_SEQ_STATS_EN
    checkOutput("b3_min", min_meas, 40'h0C0);
    checkOutput("b3_max", max_meas, 40'h140);
`else
    checkOutput("b3_min", min_meas, 0);
    checkOutput("b3_max", max_meas, 0);
`endif

    $display("[TB] timeout burst");
    d0 = done_cnt; r0 = rstlow_cnt;
    burst_len = 8'd1; timeout_cycles = 28'd50; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("to_arm", tdc_arm, 1);
    tick(51);
    checkOutput("to_wait_rst_n", tdc_rst_n, 1);
    checkOutput("to_wait_valid", out_valid, 0);
    tick(1);
    checkOutput("to_recover0", tdc_rst_n, 0);
    tick(1);
    checkOutput("to_recover1", tdc_rst_n, 0);
    tick(1);
    checkOutput("to_emit_rst_n", tdc_rst_n, 1);
    checkOutput("to_emit_valid", out_valid, 1);
    checkOutput("to_emit_data", out_data, 0);
    checkOutput("to_emit_timeout", out_timeout, 1);
    checkOutput("to_emit_idx", out_idx, 0);
    tick(1);
    checkOutput("to_done", done, 1);
    tick(1);
    checkOutput("to_rst_low_cycles", rstlow_cnt - r0, 2);
    checkOutput("to_done_count", done_cnt - d0, 1);
`ifdef TDC_SEQ_STATS_EN
    checkOutput("to_min", min_meas, 40'hFF_FFFF_FFFF);
`else
    checkOutput("to_min", min_meas, 0);
`endif
    checkOutput("to_max", max_meas, 0);

    $display("[TB] backpressure, start while busy, ARM gating");
    timeout_cycles = 28'd0; out_ready = 1'b0; burst_len = 8'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("bp_arm", tdc_arm, 1);
    applyStimulus(40'hAB_CDEF_0123, 8'd0);
    a0 = arm_cnt;
    start = 1'b1; burst_len = 8'd9;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      start = 1'b0;
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_data", out_data, 40'hAB_CDEF_0123);
    end
    checkOutput("bp_no_arm", arm_cnt - a0, 0);
    checkOutput("bp_idx_held", out_idx, 0);
    tdc_state = 2'd1; out_ready = 1'b1;
    tick(1);
    checkOutput("bp_xfer_drop", out_valid, 0);
    checkOutput("bp_idx1", out_idx, 1);
    checkOutput("bp_arm_gated", tdc_arm, 0);
    tick(1);
    checkOutput("bp_arm_gated2", tdc_arm, 0);
    checkOutput("bp_busy", busy, 1);
    tdc_state = 2'd0;
    #1;
    checkOutput("bp_arm_release", tdc_arm, 1);
    applyStimulus(40'h777, 8'd1);
    tick(1);
    checkOutput("bp_done_latched_len", done, 1);
    tick(1);

    $display("[TB] abort in WAIT");
    d0 = done_cnt;
    burst_len = 8'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    applyStimulus(40'h20, 8'd0);
    tick(1);
    checkOutput("ab_arm1", tdc_arm, 1);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("ab_recover_valid", out_valid, 0);
    checkOutput("ab_recover_rst_n", tdc_rst_n, 0);
    checkOutput("ab_recover_busy", busy, 1);
    tick(2);
    checkOutput("ab_idle", busy, 0);
    checkOutput("ab_rst_n_high", tdc_rst_n, 1);
    v0 = rise_cnt;
    tdc_meas = 40'h99; tdc_valid = 1'b1;
    tick(5);
    tdc_valid = 1'b0;
    checkOutput("ab_no_valid_rise", rise_cnt - v0, 0);
    checkOutput("ab_still_idle", busy, 0);
    checkOutput("ab_no_done", done_cnt - d0, 0);

    $display("[TB] abort coinciding with transfer");
    d0 = done_cnt;
    burst_len = 8'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    applyStimulus(40'h33, 8'd0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("abx_valid", out_valid, 0);
    checkOutput("abx_idx", out_idx, 0);
    checkOutput("abx_rst_n", tdc_rst_n, 0);
    tick(2);
    checkOutput("abx_idle", busy, 0);
    checkOutput("abx_no_done", done_cnt - d0, 0);

    $display("[TB] valid on the expiry cycle");
    r0 = rstlow_cnt;
    burst_len = 8'd1; timeout_cycles = 28'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    tdc_meas = 40'h55; tdc_valid = 1'b1;
    tick(1);
    tdc_valid = 1'b0;
    checkOutput("race_valid", out_valid, 1);
    checkOutput("race_timeout", out_timeout, 0);
    checkOutput("race_data", out_data, 40'h55);
    tick(1);
    checkOutput("race_done", done, 1);
    tick(1);
    checkOutput("race_no_rst_pulse", rstlow_cnt - r0, 0);
`ifdef TDC_SEQ_STATS_EN
    checkOutput("race_min", min_meas, 40'h55);
    checkOutput("race_max", max_meas, 40'h55);
`endif

    $display("[TB] start with zero length");
    a0 = arm_cnt;
    burst_len = 8'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("zero_busy", busy, 0);
    tick(2);
    checkOutput("zero_no_arm", arm_cnt - a0, 0);
    checkOutput("zero_still_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
